// File: rtl/fifo_grant_ctrl_pkg.sv
// ============================================================================
// Module   : fifo_grant_ctrl_pkg
// Brief    : Shared constants for the FIFO burst grant controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_grant_ctrl_pkg;

  localparam int NUM_FIFO      = 16;
  localparam int NUM_DOMAIN    = 4;
  localparam int DOMAIN_W      = 2;
  localparam int MAX_BURST_LEN = 16;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_BURST = 2'd1;
  localparam logic [STATE_W-1:0] ST_GAP   = 2'd2;

  // True when a burst length/counter width pair is usable.
  function automatic logic burst_cfg_ok(input int len, input int cnt_w);
    return (len >= 1) && (len <= MAX_BURST_LEN) && ((1 << cnt_w) >= len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_grant_fanout.sv
// ============================================================================
// Module   : fifo_grant_fanout
// Brief    : Steers the gated one-hot read vector onto the granted domain's
//            read-enable bus; all other domains stay at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_grant_fanout
  import fifo_grant_ctrl_pkg::*;
(
  input  logic [0:NUM_FIFO-1] re_vec,
  input  logic [DOMAIN_W-1:0] domain,
  output logic [0:NUM_FIFO-1] fifo_re_0,
  output logic [0:NUM_FIFO-1] fifo_re_1,
  output logic [0:NUM_FIFO-1] fifo_re_2,
  output logic [0:NUM_FIFO-1] fifo_re_3
);

  logic [0:NUM_FIFO-1] re_dom [NUM_DOMAIN];

  generate
    for (genvar d = 0; d < NUM_DOMAIN; d++) begin : g_dom
      assign re_dom[d] = (domain == DOMAIN_W'(d)) ? re_vec : '0;
    end
  endgenerate

  assign fifo_re_0 = re_dom[0];
  assign fifo_re_1 = re_dom[1];
  assign fifo_re_2 = re_dom[2];
  assign fifo_re_3 = re_dom[3];

endmodule

`default_nettype wire

// File: rtl/fifo_grant_ctrl.sv
// ============================================================================
// Module   : fifo_grant_ctrl
// Brief    : Captures the encoder's FIFO selection, holds it for a fixed-length
//            burst and issues one read-enable per acknowledged word.
//            Optional macro FIFO_GRANT_GAP_EN inserts a one-cycle GAP state
//            after each burst so FIFO empty flags settle before reselection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_grant_ctrl
  import fifo_grant_ctrl_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [0:NUM_FIFO-1] fifo_sel,
  input  logic [DOMAIN_W-1:0] fifo_sel_domain,
  input  logic                ctrl_ready,
  input  logic                ctrl_ack,
  output logic                grant_valid,
  output logic [0:NUM_FIFO-1] grant_sel,
  output logic [DOMAIN_W-1:0] grant_domain,
  output logic                burst_last,
  output logic                busy,
  output logic [0:NUM_FIFO-1] fifo_re_0,
  output logic [0:NUM_FIFO-1] fifo_re_1,
  output logic [0:NUM_FIFO-1] fifo_re_2,
  output logic [0:NUM_FIFO-1] fifo_re_3
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic             CFG_OK   = burst_cfg_ok(BURST_LEN, CNT_W);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [0:NUM_FIFO-1] grant_sel_q, grant_sel_d;
  logic [DOMAIN_W-1:0] grant_domain_q, grant_domain_d;

  logic                capture;
  logic                word_ack;
  logic                last_word;
  logic [0:NUM_FIFO-1] re_vec;

  assign capture   = (state_q == ST_IDLE) && (fifo_sel != '0) && ctrl_ready && CFG_OK;
  assign word_ack  = (state_q == ST_BURST) && ctrl_ack;
  assign last_word = (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      grant_sel_q    <= '0;
      grant_domain_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_sel_q    <= grant_sel_d;
      grant_domain_q <= grant_domain_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (word_ack && last_word) begin
`ifdef FIFO_GRANT_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst counter and grant holding registers
  always_comb begin
    cnt_d          = cnt_q;
    grant_sel_d    = grant_sel_q;
    grant_domain_d = grant_domain_q;
    if (capture) begin
      grant_sel_d    = fifo_sel;
      grant_domain_d = fifo_sel_domain;
      cnt_d          = '0;
    end else if (word_ack) begin
      cnt_d = last_word ? '0 : cnt_q + 1'b1;
    end
    // Grant is dropped on every return to IDLE so the next selection starts clean.
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      grant_sel_d    = '0;
      grant_domain_d = '0;
    end
  end

  // Outputs
  always_comb begin
    grant_valid  = (state_q == ST_BURST);
    busy         = (state_q != ST_IDLE);
    burst_last   = (state_q == ST_BURST) && last_word;
    grant_sel    = grant_sel_q;
    grant_domain = grant_domain_q;
    re_vec       = word_ack ? grant_sel_q : '0;
  end

  fifo_grant_fanout u_fanout (
    .re_vec    (re_vec),
    .domain    (grant_domain_q),
    .fifo_re_0 (fifo_re_0),
    .fifo_re_1 (fifo_re_1),
    .fifo_re_2 (fifo_re_2),
    .fifo_re_3 (fifo_re_3)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_grant_ctrl.sv
// ============================================================================
// Module   : tb_fifo_grant_ctrl
// Brief    : Directed self-checking bench for fifo_grant_ctrl (BURST_LEN=4);
//            expectations follow FIFO_GRANT_GAP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_grant_ctrl;

`ifdef FIFO_GRANT_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [0:15] fifo_sel;
  logic [1:0]  fifo_sel_domain;
  logic        ctrl_ready;
  logic        ctrl_ack;
  logic        grant_valid;
  logic [0:15] grant_sel;
  logic [1:0]  grant_domain;
  logic        burst_last;
  logic        busy;
  logic [0:15] fifo_re_0, fifo_re_1, fifo_re_2, fifo_re_3;
  logic        re_any;

  int n_checks = 0;
  int n_fail   = 0;

  assign re_any = |{fifo_re_0, fifo_re_1, fifo_re_2, fifo_re_3};

  always #5 clk = ~clk;

  fifo_grant_ctrl #(.BURST_LEN(4), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_sel        (fifo_sel),
    .fifo_sel_domain (fifo_sel_domain),
    .ctrl_ready      (ctrl_ready),
    .ctrl_ack        (ctrl_ack),
    .grant_valid     (grant_valid),
    .grant_sel       (grant_sel),
    .grant_domain    (grant_domain),
    .burst_last      (burst_last),
    .busy            (busy),
    .fifo_re_0       (fifo_re_0),
    .fifo_re_1       (fifo_re_1),
    .fifo_re_2       (fifo_re_2),
    .fifo_re_3       (fifo_re_3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [0:15] oh(input int i);
    logic [0:15] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gv"},   32'(grant_valid),  32'd0);
    check_eq({tag, "_busy"}, 32'(busy),         32'd0);
    check_eq({tag, "_gsel"}, 32'(grant_sel),    32'd0);
    check_eq({tag, "_gdom"}, 32'(grant_domain), 32'd0);
    check_eq({tag, "_last"}, 32'(burst_last),   32'd0);
    check_eq({tag, "_re"},   32'(re_any),       32'd0);
  endtask

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int acks;
  int pulses;

  initial begin
    rst             = 1'b1;
    fifo_sel        = '0;
    fifo_sel_domain = 2'd0;
    ctrl_ready      = 1'b0;
    ctrl_ack        = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // No FIFO selected: controller must stay idle.
    ctrl_ready = 1'b1;
    ctrl_ack   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_gv",   32'(grant_valid), 32'd0);
      check_eq("idle_re",   32'(re_any), 32'd0);
      next_cyc();
    end

    // Burst 1: bit 3, domain 2, ack every cycle; selection changes mid-burst.
    fifo_sel        = oh(3);
    fifo_sel_domain = 2'd2;
    @(negedge clk);
    check_eq("cap_busy", 32'(busy), 32'd0);
    check_eq("cap_re",   32'(re_any), 32'd0);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        fifo_sel        = oh(0);
        fifo_sel_domain = 2'd1;
      end
      @(negedge clk);
      check_eq("b1_gv",   32'(grant_valid), 32'd1);
      check_eq("b1_gsel", 32'(grant_sel), 32'(oh(3)));
      check_eq("b1_gdom", 32'(grant_domain), 32'd2);
      check_eq("b1_re2",  32'(fifo_re_2), 32'(oh(3)));
      check_eq("b1_re013", 32'(fifo_re_0 | fifo_re_1 | fifo_re_3), 32'd0);
      check_eq("b1_last", 32'(burst_last), 32'(i == 3));
      next_cyc();
    end
    if (GAP_EN) begin
      @(negedge clk);
      check_eq("gap_gv",   32'(grant_valid), 32'd0);
      check_eq("gap_busy", 32'(busy), 32'd1);
      check_eq("gap_gsel", 32'(grant_sel), 32'(oh(3)));
      check_eq("gap_re",   32'(re_any), 32'd0);
      next_cyc();
    end
    ctrl_ack = 1'b0;
    @(negedge clk);
    check_eq("post1_busy", 32'(busy), 32'd0);
    check_eq("post1_gsel", 32'(grant_sel), 32'd0);
    check_eq("post1_gdom", 32'(grant_domain), 32'd0);
    next_cyc();

    // Burst 2: bit 0, domain 1, irregular acks.
    acks   = 0;
    pulses = 0;
    for (int j = 0; j < 7; j++) begin
      ctrl_ack = pat[j][0];
      @(negedge clk);
      check_eq("b2_gv",   32'(grant_valid), 32'd1);
      check_eq("b2_gsel", 32'(grant_sel), 32'(oh(0)));
      check_eq("b2_gdom", 32'(grant_domain), 32'd1);
      check_eq("b2_re1",  32'(fifo_re_1), pat[j] != 0 ? 32'(oh(0)) : 32'd0);
      check_eq("b2_re023", 32'(fifo_re_0 | fifo_re_2 | fifo_re_3), 32'd0);
      check_eq("b2_last", 32'(burst_last), 32'(acks == 3));
      if (fifo_re_1 != '0) pulses++;
      if (pat[j] != 0) acks++;
      next_cyc();
    end
    check_eq("b2_pulses", 32'(pulses), 32'd4);

    // Burst 3 interrupted by asynchronous reset after the second ack.
    ctrl_ack = 1'b0;
    if (GAP_EN) begin
      @(negedge clk);
      check_eq("gap2_busy", 32'(busy), 32'd1);
      check_eq("gap2_gv",   32'(grant_valid), 32'd0);
      next_cyc();
    end
    fifo_sel        = oh(5);
    fifo_sel_domain = 2'd3;
    @(negedge clk);
    check_eq("post2_busy", 32'(busy), 32'd0);
    next_cyc();
    ctrl_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("b3_re3", 32'(fifo_re_3), 32'(oh(5)));
      next_cyc();
    end
    ctrl_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rel_busy", 32'(busy), 32'd0);
    next_cyc();
    ctrl_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b4_gv",   32'(grant_valid), 32'd1);
      check_eq("b4_re3",  32'(fifo_re_3), 32'(oh(5)));
      check_eq("b4_last", 32'(burst_last), 32'(i == 3));
      next_cyc();
    end
    @(negedge clk);
    check_eq("end_gv",   32'(grant_valid), 32'd0);
    check_eq("end_busy", 32'(busy), 32'(GAP_EN));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
